// File: rtl/ic_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
//   ic_refill_state_t : refill FSM state encoding
//   IC_OFFSET_BITS    : byte-offset bits of a block for the default 4-word, 32-bit-word geometry
package ic_pkg;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_FILL = 2'd2,
    IC_DONE = 2'd3
  } ic_refill_state_t;

  localparam int unsigned IC_BLOCK_WORDS = 4;
  localparam int unsigned IC_OFFSET_BITS = $clog2(IC_BLOCK_WORDS) + 2;

  // Byte-offset bits covered by one block of the given word count (32-bit words).
  function automatic int unsigned ic_offset_bits(input int unsigned block_words);
    return $clog2(block_words) + 2;
  endfunction

endpackage

// File: rtl/ic_refill_ctrl.sv
// Instruction-cache miss/refill controller for the Fetch stage.
// Detects a miss, requests the block from the next memory level (req/ready), then writes the
// returned words (valid) into the cache array one per beat, and finally pulses fill_done_o so
// the array sets the valid bit and tag.
// Ports:
//   clk_i, reset_i                    clock, async active-high reset
//   pc_fi_i, lookup_hit_i             Fetch PC and array tag-compare result
//   pc_src_reg_i                      bit[1] = redirect in flight
//   instr_hit_fi_o, ic_repl_permit_o  to pipeline hazard logic (0 stalls / refill outstanding)
//   mem_req_o, mem_addr_o, mem_ready_i, mem_valid_i, mem_rdata_i   next-level memory interface
//   fill_we_o, fill_word_o, fill_data_o, fill_addr_o, fill_done_o  cache array write port
module ic_refill_ctrl
  import ic_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [ADDR_WIDTH-1:0]          pc_fi_i,
  input  logic                           lookup_hit_i,
  input  logic [1:0]                     pc_src_reg_i,
  output logic                           instr_hit_fi_o,
  output logic                           ic_repl_permit_o,
  output logic                           mem_req_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic                           mem_ready_i,
  input  logic                           mem_valid_i,
  input  logic [WORD_WIDTH-1:0]          mem_rdata_i,
  output logic                           fill_we_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_o,
  output logic [WORD_WIDTH-1:0]          fill_data_o,
  output logic [ADDR_WIDTH-1:0]          fill_addr_o,
  output logic                           fill_done_o
);

  localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;

  ic_refill_state_t  state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] blk_addr_q, blk_addr_d;
  logic              redirect;

  // Byte offset of the PC and pc_src bit 0 play no part in refill control.
  logic unused_inputs;
  assign unused_inputs = ^{pc_fi_i[OFF_W-1:0], pc_src_reg_i[0]};

  assign redirect = pc_src_reg_i[1];

  // State, beat counter and latched block base.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IC_IDLE;
      cnt_q      <= '0;
      blk_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_addr_q <= blk_addr_d;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    blk_addr_d       = blk_addr_q;
    instr_hit_fi_o   = 1'b0;
    ic_repl_permit_o = 1'b0;
    mem_req_o        = 1'b0;
    fill_we_o        = 1'b0;
    fill_done_o      = 1'b0;

    unique case (state_q)
      IC_IDLE: begin
        instr_hit_fi_o   = lookup_hit_i;
        ic_repl_permit_o = 1'b1;
        // A redirect makes the missing PC stale, so it wins over the miss.
        if (!lookup_hit_i && !redirect) begin
          blk_addr_d = {pc_fi_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
          state_d    = IC_REQ;
        end
      end
      IC_REQ: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          cnt_d   = '0;
          state_d = IC_FILL;
        end else if (redirect) begin
          state_d = IC_IDLE;
        end
      end
      IC_FILL: begin
        // Once accepted the burst is always drained; redirects are ignored here.
        if (mem_valid_i) begin
          fill_we_o = 1'b1;
          cnt_d     = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(BLOCK_WORDS - 1)) begin
            state_d = IC_DONE;
          end
        end
      end
      IC_DONE: begin
        fill_done_o = 1'b1;
        cnt_d       = '0;
        state_d     = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  assign mem_addr_o  = blk_addr_q;
  assign fill_addr_o = blk_addr_q;
  assign fill_word_o = cnt_q;
  assign fill_data_o = mem_rdata_i;

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Scoreboard bench for ic_refill_ctrl: stimulus pushes expected array writes and done pulses,
// a negedge monitor pops and compares whenever the DUT writes or completes a fill.
module tb_ic_refill_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_fi;
  logic        hit;
  logic [1:0]  src;
  logic        instr_hit;
  logic        permit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic        fill_we;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic [31:0] fill_addr;
  logic        fill_done;

  ic_refill_ctrl #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .BLOCK_WORDS(4)) dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .pc_fi_i         (pc_fi),
    .lookup_hit_i    (hit),
    .pc_src_reg_i    (src),
    .instr_hit_fi_o  (instr_hit),
    .ic_repl_permit_o(permit),
    .mem_req_o       (mem_req),
    .mem_addr_o      (mem_addr),
    .mem_ready_i     (ready),
    .mem_valid_i     (valid),
    .mem_rdata_i     (rdata),
    .fill_we_o       (fill_we),
    .fill_word_o     (fill_word),
    .fill_data_o     (fill_data),
    .fill_addr_o     (fill_addr),
    .fill_done_o     (fill_done)
  );

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    logic [31:0] addr;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] dq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          req_cycles = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT write / done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) req_cycles++;
      if (fill_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {30'd0, fill_word}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_idx", {30'd0, fill_word}, {30'd0, e.idx});
          chk("wr_data", fill_data, e.data);
          chk("wr_addr", fill_addr, e.addr);
        end
      end
      if (fill_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", fill_addr, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] a;
          a = dq.pop_front();
          chk("done_addr", fill_addr, a);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full refill: rdy_wait REQ stall cycles, gap idle cycles before each beat,
  // optional redirect held during FILL.
  task automatic refill(input logic [31:0] pc, input int rdy_wait, input int gap,
                        input logic [31:0] d0, input bit redir);
    logic [31:0] blk;
    int          stalls;
    int          req0;
    blk    = {pc[31:4], 4'h0};
    stalls = 0;
    req0   = req_cycles;
    for (int i = 0; i < 4; i++) wq.push_back('{idx: 2'(i), data: d0 + 32'(i), addr: blk});
    dq.push_back(blk);
    pc_fi = pc; hit = 1'b0; src = 2'b00;
    @(negedge clk);
    if (!instr_hit) stalls++;
    chk("miss_permit", {31'd0, permit}, 32'd1);
    cyc();
    ready = 1'b0;
    for (int w = 0; w < rdy_wait; w++) begin
      @(negedge clk);
      if (!instr_hit) stalls++;
      chk("req_addr", mem_addr, blk);
      chk("req_permit", {31'd0, permit}, 32'd0);
      cyc();
    end
    ready = 1'b1;
    @(negedge clk);
    if (!instr_hit) stalls++;
    chk("req_addr", mem_addr, blk);
    cyc();
    ready = 1'b0;
    if (redir) src = 2'b10;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        valid = 1'b0;
        @(negedge clk);
        if (!instr_hit) stalls++;
        cyc();
      end
      valid = 1'b1;
      rdata = d0 + 32'(i);
      @(negedge clk);
      if (!instr_hit) stalls++;
      cyc();
    end
    valid = 1'b0;
    rdata = '0;
    @(negedge clk);
    if (!instr_hit) stalls++;
    chk("done_permit", {31'd0, permit}, 32'd0);
    cyc();
    src = 2'b00;
    hit = 1'b1;
    @(negedge clk);
    chk("hit_after_fill", {31'd0, instr_hit}, 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(7 + rdy_wait + 4 * gap));
    chk("req_cycles", 32'(req_cycles - req0), 32'(rdy_wait + 1));
    cyc();
  endtask

  initial begin
    rst = 1'b1; pc_fi = '0; hit = 1'b0; src = 2'b00;
    ready = 1'b0; valid = 1'b0; rdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_done", {31'd0, fill_done}, 32'd0);
    chk("rst_permit", {31'd0, permit}, 32'd1);
    chk("rst_fill_addr", fill_addr, 32'd0);
    cyc();
    rst = 1'b0;

    // 1: hit in IDLE
    hit = 1'b1; pc_fi = 32'h0000_1000;
    @(negedge clk);
    chk("hit_instr", {31'd0, instr_hit}, 32'd1);
    chk("hit_req", {31'd0, mem_req}, 32'd0);
    chk("hit_permit", {31'd0, permit}, 32'd1);
    cyc();

    // 2: basic miss, no wait states
    refill(32'h0000_104C, 0, 0, 32'h0000_00A0, 1'b0);

    // 3: accept delayed 3 cycles, one idle cycle before each beat
    refill(32'h0000_2238, 3, 1, 32'h0000_0D00, 1'b0);

    // 4a: redirect in REQ before accept aborts; valid in IDLE is ignored
    pc_fi = 32'h0000_3004; hit = 1'b0; src = 2'b00;
    cyc();
    src = 2'b10; ready = 1'b0;
    @(negedge clk);
    chk("abort_req_held", {31'd0, mem_req}, 32'd1);
    cyc();
    src = 2'b00; hit = 1'b1; valid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_idle_req", {31'd0, mem_req}, 32'd0);
    chk("abort_idle_permit", {31'd0, permit}, 32'd1);
    cyc();
    valid = 1'b0; rdata = '0;

    // 4b: redirect during FILL does not abort
    refill(32'h0000_4010, 1, 0, 32'h0000_0E00, 1'b1);

    // 5: miss coinciding with redirect stays IDLE
    begin
      int r0;
      r0 = req_cycles;
      pc_fi = 32'h0000_6000; hit = 1'b0; src = 2'b10;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("redir_miss_permit", {31'd0, permit}, 32'd1);
        cyc();
      end
      src = 2'b00; hit = 1'b1;
      @(negedge clk);
      chk("redir_miss_no_req", 32'(req_cycles - r0), 32'd0);
      cyc();
    end

    // 6: reset after two beats
    wq.push_back('{idx: 2'd0, data: 32'h0000_00B0, addr: 32'h0000_5000});
    wq.push_back('{idx: 2'd1, data: 32'h0000_00B1, addr: 32'h0000_5000});
    pc_fi = 32'h0000_5008; hit = 1'b0; src = 2'b00;
    cyc();
    ready = 1'b1;
    cyc();
    ready = 1'b0; valid = 1'b1; rdata = 32'h0000_00B0;
    cyc();
    rdata = 32'h0000_00B1;
    cyc();
    valid = 1'b0; rdata = '0; hit = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_permit", {31'd0, permit}, 32'd1);
    chk("async_rst_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_addr", fill_addr, 32'd0);
    chk("async_rst_word", {30'd0, fill_word}, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    refill(32'h0000_5008, 0, 0, 32'h0000_00C0, 1'b0);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
